// File: rtl/frame_pixel_server.sv
// frame_pixel_server
// Loads one grayscale frame (H x W bytes) from a valid/ready byte stream into
// an internal pixel memory.  It then serves random-access reads addressed by
// (H_read, W_read) with a one-cycle registered data path.
// Optional feature macro: FRAME_BOUND_CHECK_EN.
// When it is defined, reads outside the latched frame return 0 and pulse oob.
// Memory contents survive reset; only control state is cleared.
module frame_pixel_server #(
   parameter int ADDR_W = 16
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [15:0] H,
   input  logic [15:0] W,
   input  logic        start_load,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] W_read,
   input  logic [15:0] H_read,
   output logic [7:0]  data0,
   output logic        all_loaded,
   output logic        size_err,
   output logic        oob
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SERVE = 2'd2
   } state_t;

   // Depth as a 33-bit value so 2**32 is still representable for the compare.
   localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

   state_t            state_q, state_d;
   logic [15:0]       h_q, h_d;
   logic [15:0]       w_q, w_d;
   logic [ADDR_W-1:0] wcnt_q, wcnt_d;
   logic              in_ready_q, in_ready_d;
   logic              all_loaded_q, all_loaded_d;
   logic              size_err_q, size_err_d;
   logic              oob_q, oob_d;
   logic [7:0]        data0_q, data0_d;

   logic [7:0]        mem_q [0:(1<<ADDR_W)-1];

   logic [31:0]       npix_s;
   logic              size_ok_s;
   logic              last_s;
   logic              we_s;
   logic [ADDR_W-1:0] raddr_s;

   // Size qualification of the incoming frame and detection of the final byte.
   always_comb begin
      npix_s    = 32'(H) * 32'(W);
      size_ok_s = (npix_s != 32'd0) && ({1'b0, npix_s} <= DEPTH);
      last_s    = (32'(wcnt_q) == ((32'(h_q) * 32'(w_q)) - 32'd1));
      // A start_load in LOAD restarts the frame, so the byte offered on that
      // same cycle belongs to the abandoned frame and is not written.
      we_s      = in_ready_q && in_valid && !start_load;
   end

   // Next-state logic: frame start/restart, byte acceptance and completion.
   always_comb begin
      state_d    = state_q;
      h_d        = h_q;
      w_d        = w_q;
      wcnt_d     = wcnt_q;
      size_err_d = size_err_q;
      if (start_load) begin
         if (size_ok_s) begin
            state_d    = LOAD;
            h_d        = H;
            w_d        = W;
            wcnt_d     = {ADDR_W{1'b0}};
            size_err_d = 1'b0;
         end else begin
            state_d    = IDLE;
            size_err_d = 1'b1;
         end
      end else begin
         case (state_q)
            IDLE:    state_d = IDLE;
            LOAD: begin
               if (in_valid) begin
                  wcnt_d = wcnt_q + ADDR_W'(1);
                  if (last_s) begin
                     state_d = SERVE;
                  end else begin
                     state_d = LOAD;
                  end
               end else begin
                  state_d = LOAD;
               end
            end
            SERVE:   state_d = SERVE;
            default: state_d = IDLE;
         endcase
      end
      in_ready_d   = (state_d == LOAD);
      all_loaded_d = (state_d == SERVE);
   end

   // Read address (row-major, wraps modulo the memory depth) and read data.
   always_comb begin
      raddr_s = (ADDR_W'(H_read) * ADDR_W'(w_q)) + ADDR_W'(W_read);
`ifdef FRAME_BOUND_CHECK_EN
      oob_d = (W_read >= w_q) || (H_read >= h_q);
      if (oob_d) begin
         data0_d = 8'd0;
      end else begin
         data0_d = mem_q[raddr_s];
      end
`else
      oob_d   = 1'b0;
      data0_d = mem_q[raddr_s];
`endif
   end

   // Pixel memory write port; deliberately not reset so frames survive rstn.
   always_ff @(posedge clk) begin
      if (we_s) begin
         mem_q[wcnt_q] <= in_data;
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         h_q          <= 16'd0;
         w_q          <= 16'd0;
         wcnt_q       <= {ADDR_W{1'b0}};
         in_ready_q   <= 1'b0;
         all_loaded_q <= 1'b0;
         size_err_q   <= 1'b0;
         oob_q        <= 1'b0;
         data0_q      <= 8'd0;
      end else begin
         state_q      <= state_d;
         h_q          <= h_d;
         w_q          <= w_d;
         wcnt_q       <= wcnt_d;
         in_ready_q   <= in_ready_d;
         all_loaded_q <= all_loaded_d;
         size_err_q   <= size_err_d;
         oob_q        <= oob_d;
         data0_q      <= data0_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign all_loaded = all_loaded_q;
   assign size_err   = size_err_q;
   assign oob        = oob_q;
   assign data0      = data0_q;

endmodule

// File: tb/tb_frame_pixel_server.sv
// Self-checking bench for frame_pixel_server (built with ADDR_W=8).
// A transaction-level model predicts every output each cycle.  Directed
// literal checks pin both the model and the DUT to hand-computed values.
module tb_frame_pixel_server;

   localparam int AW    = 8;
   localparam int DEPTH = 1 << AW;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [15:0] H = 16'd0, W = 16'd0, W_read = 16'd0, H_read = 16'd0;
   logic        start_load = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        in_valid = 1'b0;
   logic        in_ready, all_loaded, size_err, oob;
   logic [7:0]  data0;

   int n_cmp = 0;
   int n_bad = 0;

   frame_pixel_server #(.ADDR_W(AW)) dut (
      .clk(clk), .rstn(rstn), .H(H), .W(W), .start_load(start_load),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .W_read(W_read), .H_read(H_read), .data0(data0),
      .all_loaded(all_loaded), .size_err(size_err), .oob(oob)
   );

   always #5 clk = ~clk;

   function automatic void chk(string nm, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural model ----------------
   int        m_mode;            // 0 idle, 1 loading, 2 serving
   int        m_h, m_w, m_cnt;
   bit        m_serr;
   bit [7:0]  m_mem [int];       // frame bytes ever written (survive reset)
   bit        e_rdy, e_all, e_serr, e_oob, e_known;
   bit [7:0]  e_d;

   // Model update: one step per clock edge from the inputs seen at that edge.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_mode = 0; m_h = 0; m_w = 0; m_cnt = 0; m_serr = 0;
         e_rdy = 0; e_all = 0; e_serr = 0; e_oob = 0; e_d = 8'd0; e_known = 1;
      end else begin
         longint a;
         longint n;
         a = (longint'(H_read) * m_w + longint'(W_read)) % DEPTH;
         e_oob = 0;
`ifdef FRAME_BOUND_CHECK_EN
         if (int'(W_read) >= m_w || int'(H_read) >= m_h) e_oob = 1;
`endif
         if (e_oob) begin
            e_d = 8'd0; e_known = 1;
         end else if (m_mem.exists(int'(a))) begin
            e_d = m_mem[int'(a)]; e_known = 1;
         end else begin
            e_known = 0;
         end
         if (start_load) begin
            n = longint'(H) * longint'(W);
            if (n == 0 || n > DEPTH) begin
               m_serr = 1; m_mode = 0;
            end else begin
               m_h = H; m_w = W; m_cnt = 0; m_mode = 1; m_serr = 0;
            end
         end else if (m_mode == 1 && in_valid) begin
            m_mem[m_cnt] = in_data;
            m_cnt++;
            if (m_cnt == m_h * m_w) m_mode = 2;
         end
         e_rdy = (m_mode == 1); e_all = (m_mode == 2); e_serr = m_serr;
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(posedge clk) begin
      #1;
      chk("m_in_ready",   int'(in_ready),   int'(e_rdy));
      chk("m_all_loaded", int'(all_loaded), int'(e_all));
      chk("m_size_err",   int'(size_err),   int'(e_serr));
      chk("m_oob",        int'(oob),        int'(e_oob));
      if (e_known) chk("m_data0", int'(data0), int'(e_d));
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int rdy;
      #1;
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_all_loaded", int'(all_loaded), 0);
      chk("rst_size_err", int'(size_err), 0);
      chk("rst_oob", int'(oob), 0);
      chk("rst_data0", int'(data0), 0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      // 4x5 frame, bytes 0x00..0x13, valid held high
      H = 16'd4; W = 16'd5; start_load = 1'b1;
      @(negedge clk);
      start_load = 1'b0; in_valid = 1'b1; rdy = 0;
      for (int i = 0; i < 20; i++) begin
         in_data = 8'(i);
         if (in_ready) rdy++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("ready_cycles", rdy, 20);
      chk("loaded_after_20", int'(all_loaded), 1);
      chk("ready_off_serve", int'(in_ready), 0);

      H_read = 16'd2; W_read = 16'd3;
      @(negedge clk);
      chk("read_2_3", int'(data0), 8'h0D);
      W_read = 16'd5; H_read = 16'd0;
      @(negedge clk);
`ifdef FRAME_BOUND_CHECK_EN
      chk("oob_data0", int'(data0), 0);
      chk("oob_pulse", int'(oob), 1);
`else
      chk("wrap_data0", int'(data0), 8'h05);
      chk("no_oob", int'(oob), 0);
`endif
      H_read = 16'd3; W_read = 16'd4;
      @(negedge clk);
      chk("read_3_4", int'(data0), 8'h13);
      chk("oob_one_cycle", int'(oob), 0);

      // restart from SERVE, partial load of 10 bytes, then reset mid-load
      H = 16'd4; W = 16'd5; start_load = 1'b1;
      @(negedge clk);
      start_load = 1'b0;
      chk("loaded_drop", int'(all_loaded), 0);
      chk("restart_ready", int'(in_ready), 1);
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = 8'h40 + 8'(i);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("partial_not_loaded", int'(all_loaded), 0);
      rstn = 1'b0;
      #1;
      chk("mid_rst_in_ready", int'(in_ready), 0);
      chk("mid_rst_all_loaded", int'(all_loaded), 0);
      chk("mid_rst_size_err", int'(size_err), 0);
      chk("mid_rst_oob", int'(oob), 0);
      chk("mid_rst_data0", int'(data0), 0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
`ifdef FRAME_BOUND_CHECK_EN
      chk("post_rst_oob", int'(oob), 1);
`else
      chk("mem_retained", int'(data0), 8'h44);
`endif

      // reload with in_valid toggling; read address 0 collides with first write
      H_read = 16'd0; W_read = 16'd0;
      H = 16'd4; W = 16'd5; start_load = 1'b1;
      @(negedge clk);
      start_load = 1'b0;
      for (int c = 0; c < 40; c++) begin
         in_valid = ((c % 2) == 0);
         in_data  = 8'h80 + 8'(c / 2);
         @(negedge clk);
         if (c == 0) chk("read_old_on_write", int'(data0), 8'h40);
         if (c == 20) chk("toggle_half_ready", int'(in_ready), 1);
      end
      in_valid = 1'b0;
      chk("toggle_loaded", int'(all_loaded), 1);
      H_read = 16'd1; W_read = 16'd2;
      @(negedge clk);
      chk("reload_read_1_2", int'(data0), 8'h87);

      // size errors and the exact-depth boundary
      H = 16'd0; W = 16'd7; start_load = 1'b1;
      @(negedge clk);
      start_load = 1'b0;
      chk("zero_size_err", int'(size_err), 1);
      chk("zero_in_ready", int'(in_ready), 0);
      chk("zero_all_loaded", int'(all_loaded), 0);
      H = 16'd16; W = 16'd17; start_load = 1'b1;
      @(negedge clk);
      start_load = 1'b0;
      chk("big_size_err", int'(size_err), 1);
      H = 16'd16; W = 16'd16; start_load = 1'b1;
      @(negedge clk);
      start_load = 1'b0;
      chk("full_size_clear", int'(size_err), 0);
      chk("full_in_ready", int'(in_ready), 1);
      in_valid = 1'b1;
      for (int i = 0; i < 256; i++) begin
         in_data = 8'(i) ^ 8'h5A;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("full_loaded", int'(all_loaded), 1);
      H_read = 16'd15; W_read = 16'd15;
      @(negedge clk);
      chk("full_last_pixel", int'(data0), 8'hA5);
      H_read = 16'd16; W_read = 16'd0;
      @(negedge clk);
`ifdef FRAME_BOUND_CHECK_EN
      chk("row_oob", int'(oob), 1);
`else
      chk("addr_truncate", int'(data0), 8'h5A);
`endif
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
